// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pipe_pkg
// Purpose  : default widths and bubble encoding for the pipe_stage_reg slice
// Revision : 1.0
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int PIPE_DATA_W = 138;
  localparam int PIPE_CTRL_W = 9;
  localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pipe_slot
// Purpose  : one pipeline entry (valid/data/ctrl); clear beats load
// Revision : 1.0
// ---------------------------------------------------------------------------
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = PIPE_DATA_W,
  parameter int                 CTRL_W   = PIPE_CTRL_W,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = CTRL_W'(PIPE_CTRL_NOP)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  // An empty slot always carries zero data and the bubble control value.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clear_i) begin
      valid_d = 1'b0;
      data_d  = '0;
      ctrl_d  = CTRL_NOP;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= CTRL_NOP;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pipe_stage_reg
// Purpose  : valid/ready pipeline register; PIPE_SKID_EN adds a skid slot so
//            in_ready is purely registered
// Revision : 1.0
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = PIPE_DATA_W,
  parameter int                 CTRL_W   = PIPE_CTRL_W,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = CTRL_W'(PIPE_CTRL_NOP)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_data_in;
  logic [CTRL_W-1:0] main_ctrl_in;
  logic              in_xfer;
  logic              out_hs;

  assign in_xfer = in_valid & in_ready;
  assign out_hs  = main_valid & out_ready;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              skid_load;
  logic              skid_clear;

  assign in_ready = ~skid_valid;

  // The skid slot only fills when the main slot is stalled; it refills main on the next handshake.
  always_comb begin
    main_load    = 1'b0;
    skid_load    = 1'b0;
    main_data_in = in_data;
    main_ctrl_in = in_ctrl;
    if (skid_valid) begin
      main_load    = out_hs;
      main_data_in = skid_data;
      main_ctrl_in = skid_ctrl;
    end else if (in_xfer) begin
      main_load = ~main_valid | out_ready;
      skid_load = main_valid & ~out_ready;
    end
    main_clear = flush | (out_hs & ~main_load);
    skid_clear = flush | (skid_valid & out_hs);
  end

  pipe_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_NOP (CTRL_NOP)
  ) u_skid (
    .CLK     (CLK),
    .reset   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (in_data),
    .ctrl_i  (in_ctrl),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .ctrl_o  (skid_ctrl)
  );
`else
  assign in_ready     = ~main_valid | out_ready;
  assign main_load    = in_xfer;
  assign main_clear   = flush | (out_hs & ~in_xfer);
  assign main_data_in = in_data;
  assign main_ctrl_in = in_ctrl;
`endif

  pipe_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_NOP (CTRL_NOP)
  ) u_main (
    .CLK     (CLK),
    .reset   (reset),
    .load_i  (main_load),
    .clear_i (main_clear),
    .data_i  (main_data_in),
    .ctrl_i  (main_ctrl_in),
    .valid_o (main_valid),
    .data_o  (main_data),
    .ctrl_o  (main_ctrl)
  );

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_pipe_stage_reg
// Purpose  : directed table, corner sequences and queue-model random traffic
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DATA_W = PIPE_DATA_W;
  localparam int CTRL_W = PIPE_CTRL_W;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int CAP = SKID ? 2 : 1;

  logic              CLK = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_NOP (PIPE_CTRL_NOP)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic [8:0]  c;
    logic        ordy;
    logic        fl;
    logic        e_rdy;
    logic        e_v;
    logic [15:0] e_d;
    logic [8:0]  e_c;
  } vec_t;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } ent_t;

  vec_t tbl [9];
  ent_t q [$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic ev, input logic [159:0] ed, input logic [159:0] ec);
    chk({name, "_v"}, 160'(out_valid), 160'(ev));
    chk({name, "_d"}, 160'(out_data), ed);
    chk({name, "_c"}, 160'(out_ctrl), ec);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One cycle of traffic checked against an occupancy queue: ready while
  // there is room (or, single-slot, when the head leaves this cycle).
  task automatic model_cycle(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                             input logic ordy, input logic fl);
    logic exp_rdy;
    logic acc;
    logic hs;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = (q.size() < CAP) || (!SKID && ordy);
    chk("rnd_rdy", 160'(in_ready), 160'(exp_rdy));
    chk("rnd_valid", 160'(out_valid), 160'(q.size() > 0));
    if (q.size() > 0) begin
      chk("rnd_data", 160'(out_data), 160'(q[0].d));
      chk("rnd_ctrl", 160'(out_ctrl), 160'(q[0].c));
    end else begin
      chk("rnd_data", 160'(out_data), 160'(0));
      chk("rnd_ctrl", 160'(out_ctrl), 160'(PIPE_CTRL_NOP));
    end
    acc = iv && exp_rdy;
    hs  = (q.size() > 0) && ordy;
    if (fl) begin
      q.delete();
    end else begin
      if (hs) void'(q.pop_front());
      if (acc) q.push_back('{d: d, c: c});
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //          iv  d       c       ordy fl  rdy v  e_d     e_c
    tbl[0] = '{1'b1, 16'h0001, 9'h001, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 9'h001};
    tbl[1] = '{1'b1, 16'h0002, 9'h002, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 9'h002};
    tbl[2] = '{1'b1, 16'h0003, 9'h003, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 9'h003};
    tbl[3] = '{1'b1, 16'h0004, 9'h004, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0004, 9'h004};
    tbl[4] = '{1'b1, 16'h003C, 9'h005, 1'b1, 1'b0, 1'b1, 1'b1, 16'h003C, 9'h005};
    tbl[5] = '{1'b0, 16'h0000, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 9'h000};
    tbl[6] = '{1'b1, 16'h0077, 9'h003, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0077, 9'h003};
    tbl[7] = '{1'b1, 16'h0099, 9'h1FF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 9'h000};
    tbl[8] = '{1'b0, 16'h0000, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 9'h000};

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_out("reset", 1'b0, 160'(0), 160'(0));
    reset = 1'b0;
    #1;
    chk("reset_rdy", 160'(in_ready), 160'(1));

    for (int i = 0; i < 9; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = DATA_W'(tbl[i].d);
      in_ctrl   = CTRL_W'(tbl[i].c);
      out_ready = tbl[i].ordy;
      flush     = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_rdy", i), 160'(in_ready), 160'(tbl[i].e_rdy));
      tick();
      chk_out($sformatf("tbl%0d", i), tbl[i].e_v, 160'(tbl[i].e_d), 160'(tbl[i].e_c));
    end
    flush = 1'b0;

    // Stall: 0xA5 held for three cycles while 0xA6 is offered
    in_valid  = 1'b1;
    in_data   = DATA_W'(16'h00A5);
    in_ctrl   = 9'h011;
    out_ready = 1'b0;
    tick();
    chk_out("stall_load", 1'b1, 160'(16'h00A5), 160'(9'h011));
    in_data = DATA_W'(16'h00A6);
    in_ctrl = 9'h012;
    #1;
    chk("stall1_rdy", 160'(in_ready), 160'(SKID));
    tick();
    chk_out("stall1", 1'b1, 160'(16'h00A5), 160'(9'h011));
    chk("stall2_rdy", 160'(in_ready), 160'(0));
    out_ready = 1'b1;
    #1;
    chk("comb_path_rdy", 160'(in_ready), 160'(!SKID));
    out_ready = 1'b0;
    #1;
    tick();
    chk_out("stall2", 1'b1, 160'(16'h00A5), 160'(9'h011));
    chk("stall3_rdy", 160'(in_ready), 160'(0));
    tick();
    chk_out("stall3", 1'b1, 160'(16'h00A5), 160'(9'h011));
    out_ready = 1'b1;
    #1;
    chk("release_rdy", 160'(in_ready), 160'(!SKID));
    tick();
    chk_out("release", 1'b1, 160'(16'h00A6), 160'(9'h012));
    in_valid = 1'b0;
    #1;
    chk("after_rdy", 160'(in_ready), 160'(1));
    tick();
    chk_out("after", 1'b0, 160'(0), 160'(0));

    // Asynchronous reset in the middle of a stalled cycle
    in_valid  = 1'b1;
    in_data   = DATA_W'(16'h005A);
    in_ctrl   = 9'h021;
    out_ready = 1'b0;
    tick();
    in_data = DATA_W'(16'h005B);
    tick();
    chk_out("prerst", 1'b1, 160'(16'h005A), 160'(9'h021));
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk_out("midrst", 1'b0, 160'(0), 160'(0));
    @(posedge CLK);
    #3;
    reset = 1'b0;
    #1;
    chk("postrst_rdy", 160'(in_ready), 160'(1));
    tick();
    chk_out("postrst", 1'b0, 160'(0), 160'(0));

    // Random traffic against the queue model, then drain
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [159:0] rw;
      rw = {$urandom, $urandom, $urandom, $urandom, $urandom};
      model_cycle(($urandom_range(0, 3) != 0), rw[DATA_W-1:0], CTRL_W'($urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      model_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
